// File: rtl/multicycle_pkg.sv
// Shared types for the multicycle controller.
// States, opcodes, control bundle and counter width.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        ADDR   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB_ALU = 4'd6,
        WB_MEM = 4'd7,
        JUMP   = 4'd8
    } state_t;

    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;
    localparam logic [1:0] OP_J  = 2'b11;

    localparam int RCW = 16;

    typedef struct packed {
        logic mem_req;
        logic mem_we;
        logic iord;
        logic ir_write;
        logic pc_write;
        logic pc_src;
        logic reg_dst;
        logic reg_write;
        logic alu_src;
        logic alu_op;
        logic mem_to_reg;
        logic retire;
    } ctrl_t;

endpackage

// File: rtl/multicycle_outdec.sv
// Combinational control and next-state decode.
// Everything is forced low while reset is held.
module multicycle_outdec
    import multicycle_pkg::*;
(
    input  logic [3:0] state,
    input  logic [1:0] opcode,
    input  logic       mem_ready,
    input  logic       run,
    input  logic       rst_n,
    output ctrl_t      ctrl,
    output state_t     nxt
);

    ctrl_t c;

    always_comb begin
        c   = '0;
        nxt = FETCH;
        unique case (state)
            FETCH: begin
                nxt = FETCH;
                if (run) begin
                    c.mem_req = 1'b1;
                    if (mem_ready) begin
                        c.ir_write = 1'b1;
                        c.pc_write = 1'b1;
                        nxt        = DECODE;
                    end
                end
            end
            DECODE: begin
                unique case (1'b1)
                    (opcode == OP_R): nxt = EXEC_R;
                    (opcode == OP_J): nxt = JUMP;
                    default:          nxt = ADDR;
                endcase
            end
            EXEC_R: begin
                c.alu_op = 1'b1;
                nxt      = WB_ALU;
            end
            WB_ALU: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            ADDR: begin
                c.alu_src = 1'b1;
                nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.alu_src = 1'b1;
                nxt = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
                c.alu_src = 1'b1;
                c.retire  = mem_ready;
                nxt = mem_ready ? FETCH : MEM_WR;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 1'b1;
                c.retire   = 1'b1;
            end
            default: nxt = FETCH;
        endcase
        ctrl = rst_n ? c : '0;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: state, opcode and retire counter.
// Decode lives in multicycle_outdec.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [7:0]     instr,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           iord,
    output logic           ir_write,
    output logic           pc_write,
    output logic           pc_src,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src,
    output logic           alu_op,
    output logic           mem_to_reg,
    output logic           retire,
    output logic [3:0]     state,
    output logic [RCW-1:0] retire_count
);

    state_t         st;
    state_t         nxt;
    logic [1:0]     opc;
    logic [RCW-1:0] cnt;
    ctrl_t          ctrl;
    logic           unused_instr;

    assign unused_instr = ^instr[5:0];

    multicycle_outdec u_outdec (
        .state     (st),
        .opcode    (opc),
        .mem_ready (mem_ready),
        .run       (run),
        .rst_n     (rst_n),
        .ctrl      (ctrl),
        .nxt       (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= FETCH;
            opc <= OP_R;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (ctrl.ir_write)
                opc <= instr[7:6];
            if (ctrl.retire)
                cnt <= cnt + 1'b1;
        end
    end

    assign mem_req      = ctrl.mem_req;
    assign mem_we       = ctrl.mem_we;
    assign iord         = ctrl.iord;
    assign ir_write     = ctrl.ir_write;
    assign pc_write     = ctrl.pc_write;
    assign pc_src       = ctrl.pc_src;
    assign reg_dst      = ctrl.reg_dst;
    assign reg_write    = ctrl.reg_write;
    assign alu_src      = ctrl.alu_src;
    assign alu_op       = ctrl.alu_op;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign retire       = ctrl.retire;
    assign state        = st;
    assign retire_count = cnt;

endmodule
